// File: rtl/seq_mult_pkg.sv
// Shared state encoding and operand-extension helper for the sequential multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Extension bit that widens a WIDTH-bit operand to WIDTH+1 bits.
    function automatic logic sext1(input logic msb, input logic signed_flag);
        return signed_flag & msb;
    endfunction

endpackage

// File: rtl/seq_mult_add_sub.sv
// Purpose: (WIDTH+1)-bit add/subtract of A and S, sign- or zero-extended per mode.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the controller in its ADD state.
module add_sub_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             sub_i,
    input  logic             signed_mode_i,
    output logic [WIDTH:0]   sum_o
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] s_ext;

    assign a_ext = {sext1(a_i[WIDTH-1], signed_mode_i), a_i};
    assign s_ext = {sext1(s_i[WIDTH-1], signed_mode_i), s_i};

    // Subtraction only occurs for the sign-bit partial product in signed mode.
    assign sum_o = sub_i ? (a_ext - s_ext) : (a_ext + s_ext);

endmodule

// File: rtl/seq_mult_unit.sv
// Purpose: shift-add multiplier, {A,B} = S*B + A with signed/unsigned and accumulate modes.
// Latency: Start accepted at edge k, Busy for 2*WIDTH cycles, Done pulse after edge k+2*WIDTH.
// Backpressure: Start/Load_B/Clear_A are ignored outside IDLE; Start held high retries next IDLE.
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Load_B,
    input  logic             Clear_A,
    input  logic             Accum,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aout,
    output logic [WIDTH-1:0] Bout,
    output logic             Xout,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             mode_q, mode_d;

    logic             last_iter;
    logic [WIDTH:0]   sum;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    add_sub_unit #(
        .WIDTH (WIDTH)
    ) u_add_sub (
        .a_i           (a_q),
        .s_i           (s_q),
        .sub_i         (mode_q & last_iter),
        .signed_mode_i (mode_q),
        .sum_o         (sum)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = ADD;
                    s_d     = Din;
                    mode_d  = Signed_Mode;
                    cnt_d   = '0;
                    if (Accum) begin
                        // X must mirror A's sign so the first shift stays arithmetic.
                        x_d = sext1(a_q[WIDTH-1], Signed_Mode);
                    end else begin
                        x_d = 1'b0;
                        a_d = '0;
                    end
                end else begin
                    if (Clear_A) begin
                        x_d = 1'b0;
                        a_d = '0;
                    end
                    if (Load_B) begin
                        b_d = Din;
                    end
                end
            end
            ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = sum;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                x_d = mode_q & x_q;
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (last_iter) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            mode_q  <= mode_d;
        end
    end

    assign Aout = a_q;
    assign Bout = b_q;
    assign Xout = x_q;
    assign Busy = (state_q == ADD) || (state_q == SHIFT);
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_seq_mult_unit.sv
// Scoreboard bench for seq_mult_unit at WIDTH 8, 16 and 2.
module tb_seq_mult_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 0, loadb8 = 0, cleara8 = 0, accum8 = 0, sm8 = 0;
    logic [7:0] din8 = '0;
    logic [7:0] a8, b8;
    logic       x8, busy8, done8;

    seq_mult_unit #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst_n), .Start(start8), .Load_B(loadb8), .Clear_A(cleara8),
        .Accum(accum8), .Signed_Mode(sm8), .Din(din8),
        .Aout(a8), .Bout(b8), .Xout(x8), .Busy(busy8), .Done(done8)
    );

    // WIDTH=16 instance
    logic        start16 = 0, loadb16 = 0, sm16 = 0;
    logic [15:0] din16 = '0;
    logic [15:0] a16, b16;
    logic        x16, busy16, done16;

    seq_mult_unit #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst_n), .Start(start16), .Load_B(loadb16), .Clear_A(1'b0),
        .Accum(1'b0), .Signed_Mode(sm16), .Din(din16),
        .Aout(a16), .Bout(b16), .Xout(x16), .Busy(busy16), .Done(done16)
    );

    // WIDTH=2 instance
    logic       start2 = 0, loadb2 = 0;
    logic [1:0] din2 = '0;
    logic [1:0] a2, b2;
    logic       x2, busy2, done2;

    seq_mult_unit #(.WIDTH(2)) dut2 (
        .Clk(clk), .Reset(rst_n), .Start(start2), .Load_B(loadb2), .Clear_A(1'b0),
        .Accum(1'b0), .Signed_Mode(1'b0), .Din(din2),
        .Aout(a2), .Bout(b2), .Xout(x2), .Busy(busy2), .Done(done2)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] q8[$];
    logic [63:0] q16[$];
    logic [63:0] q2[$];
    int busy8_cnt = 0, busy16_cnt = 0, busy2_cnt = 0;

    logic [7:0] a_m = '0;
    logic [7:0] b_m = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: S*B + A_init in 2*w bits, operands extended per mode.
    function automatic logic [63:0] model(input int w, input logic [31:0] s, input logic [31:0] b,
                                          input logic [31:0] a, input logic sg, input logic acc);
        longint sv, bv, av, p;
        sv = longint'(s);
        bv = longint'(b);
        av = longint'(a);
        if (sg && s[w-1]) sv = sv - (longint'(1) << w);
        if (sg && b[w-1]) bv = bv - (longint'(1) << w);
        if (sg && a[w-1]) av = av - (longint'(1) << w);
        if (!acc) av = 0;
        p = sv * bv + av;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            busy8_cnt = 0;
        end else begin
            if (busy8) busy8_cnt++;
            if (done8) begin
                if (q8.size() == 0) begin
                    chk("done8_spurious", 64'd1, 64'd0);
                end else begin
                    e = q8.pop_front();
                    chk("prod8", 64'({a8, b8}), e);
                end
                chk("busy8_len", 64'(busy8_cnt), 64'd16);
                busy8_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            busy16_cnt = 0;
            busy2_cnt  = 0;
        end else begin
            if (busy16) busy16_cnt++;
            if (busy2) busy2_cnt++;
            if (done16) begin
                if (q16.size() == 0) chk("done16_spurious", 64'd1, 64'd0);
                else begin
                    e = q16.pop_front();
                    chk("prod16", 64'({a16, b16}), e);
                end
                chk("busy16_len", 64'(busy16_cnt), 64'd32);
                busy16_cnt = 0;
            end
            if (done2) begin
                if (q2.size() == 0) chk("done2_spurious", 64'd1, 64'd0);
                else begin
                    e = q2.pop_front();
                    chk("prod2", 64'({a2, b2}), e);
                end
                chk("busy2_len", 64'(busy2_cnt), 64'd4);
                busy2_cnt = 0;
            end
        end
    end

    task automatic do_load_b(input logic [7:0] v);
        @(posedge clk); #1;
        din8 = v; loadb8 = 1;
        @(posedge clk); #1;
        loadb8 = 0;
        b_m = v;
    endtask

    task automatic do_clear_a;
        @(posedge clk); #1;
        cleara8 = 1;
        @(posedge clk); #1;
        cleara8 = 0;
        a_m = '0;
    endtask

    task automatic start_op(input logic [7:0] s, input logic acc, input logic sg);
        logic [63:0] e;
        @(posedge clk); #1;
        din8 = s; accum8 = acc; sm8 = sg; start8 = 1;
        e = model(8, 32'(s), 32'(b_m), 32'(a_m), sg, acc);
        q8.push_back(e);
        a_m = e[15:8];
        b_m = e[7:0];
        @(posedge clk); #1;
        start8 = 0;
        // Operand and mode must be latched at Start, not tracked.
        din8 = ~s; sm8 = ~sg; accum8 = ~acc;
    endtask

    task automatic wait_done8(input string tag);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk(tag, 64'd0, 64'd1);
    endtask

    task automatic do_op(input logic [7:0] s, input logic acc, input logic sg);
        start_op(s, acc, sg);
        wait_done8("done8_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_ab", 64'({a8, b8}), 64'd0);
        chk("rst_x", 64'(x8), 64'd0);
        chk("rst_busy_done", 64'({busy8, done8}), 64'd0);
        @(posedge clk); #2;
        rst_n = 1;

        // Unsigned max operands
        do_load_b(8'hFF);
        do_op(8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_ab", 64'({a8, b8}), 64'hFE01);
        chk("hold_x", 64'(x8), 64'd0);

        // Signed products, including a negative accumulate
        do_load_b(8'hFD);
        do_op(8'h07, 1'b0, 1'b1);
        do_load_b(8'h02);
        do_op(8'h03, 1'b1, 1'b1);
        do_load_b(8'hFF);
        do_op(8'hFF, 1'b0, 1'b1);
        do_load_b(8'h80);
        do_op(8'h80, 1'b0, 1'b1);

        // Unsigned accumulate onto A=5
        do_clear_a;
        chk("clear_a", 64'({x8, a8}), 64'd0);
        do_load_b(8'h10);
        do_op(8'h50, 1'b0, 1'b0);
        do_load_b(8'h04);
        do_op(8'h03, 1'b1, 1'b0);

        // Control inputs pulsed while busy must be ignored
        do_load_b(8'h23);
        start_op(8'h11, 1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            repeat (p == 0 ? 1 : 6) @(posedge clk);
            #1;
            start8 = 1; loadb8 = 1; cleara8 = 1; din8 = 8'hAA;
            @(posedge clk); #1;
            start8 = 0; loadb8 = 0; cleara8 = 0;
        end
        wait_done8("done8_timeout_hs");

        // Asynchronous reset mid-operation
        do_load_b(8'h55);
        @(posedge clk); #1;
        din8 = 8'h33; accum8 = 0; sm8 = 0; start8 = 1;
        @(posedge clk); #1;
        start8 = 0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("midrst_ab", 64'({a8, b8}), 64'd0);
        chk("midrst_x", 64'(x8), 64'd0);
        chk("midrst_busy_done", 64'({busy8, done8}), 64'd0);
        @(posedge clk); #2;
        rst_n = 1;
        a_m = '0;
        b_m = '0;
        do_load_b(8'h0A);
        do_op(8'h0C, 1'b0, 1'b0);

        // Back-to-back: Start held high through DONE
        do_load_b(8'h03);
        @(posedge clk); #1;
        din8 = 8'h05; accum8 = 0; sm8 = 0; start8 = 1;
        q8.push_back(model(8, 32'h5, 32'(b_m), 32'(a_m), 1'b0, 1'b0));
        b_m = 8'h0F; a_m = 8'h00;
        wait_done8("done8_timeout_b2b1");
        q8.push_back(model(8, 32'h5, 32'(b_m), 32'(a_m), 1'b0, 1'b0));
        @(negedge clk);
        chk("b2b_gap", 64'(busy8), 64'd0);
        @(negedge clk);
        chk("b2b_restart", 64'(busy8), 64'd1);
        start8 = 0;
        wait_done8("done8_timeout_b2b2");

        // WIDTH=16 signed
        @(posedge clk); #1;
        din16 = 16'h7FFF; loadb16 = 1;
        @(posedge clk); #1;
        loadb16 = 0; din16 = 16'h8000; sm16 = 1; start16 = 1;
        q16.push_back(model(16, 32'h8000, 32'h7FFF, 32'h0, 1'b1, 1'b0));
        @(posedge clk); #1;
        start16 = 0; din16 = 16'h1234; sm16 = 0;
        begin
            bit seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (done16) begin seen = 1; break; end
            end
            if (!seen) chk("done16_timeout", 64'd0, 64'd1);
        end

        // WIDTH=2 unsigned
        @(posedge clk); #1;
        din2 = 2'd3; loadb2 = 1;
        @(posedge clk); #1;
        loadb2 = 0; start2 = 1;
        q2.push_back(model(2, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0));
        @(posedge clk); #1;
        start2 = 0; din2 = 2'd0;
        begin
            bit seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (done2) begin seen = 1; break; end
            end
            if (!seen) chk("done2_timeout", 64'd0, 64'd1);
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q16_drained", 64'(q16.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
